// File: rtl/mem_stage_pkg.sv
// mem_stage shared types: bus layouts, load codes, stall indices.
// Imported by mem_stage and load_align.
package mem_stage_pkg;

  localparam int EX_TO_DC_WD  = 152;
  localparam int DC_TO_MEM_WD = EX_TO_DC_WD;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_RF_WD = 104;
  localparam int STALL_WD     = 7;

  localparam int STALL_OWN = 5;
  localparam int STALL_WB  = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;

  localparam int IS_LOAD_BIT = 151;
  localparam int LD_TYPE_HI  = 150;
  localparam int LD_TYPE_LO  = 148;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } mem_st_e;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  ld_type;
    logic [4:0]  rsv_hi;
    logic [65:0] hilo;
    logic [31:0] pc;
    logic [5:0]  rsv_lo;
    logic        valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } dc_to_mem_t;

  typedef struct packed {
    logic [65:0] hilo;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic [65:0] hilo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_rf_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: byte/half select by address,
// then sign or zero extension by load type.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_word[31:16]
                            : i_word[15:0];

  always_comb begin
    o_result = i_word;
    unique case (1'b1)
      (i_ld_type == LD_LB):
        o_result = {{24{w_byte[7]}}, w_byte};
      (i_ld_type == LD_LBU):
        o_result = {24'h0, w_byte};
      (i_ld_type == LD_LH):
        o_result = {{16{w_half[15]}}, w_half};
      (i_ld_type == LD_LHU):
        o_result = {16'h0, w_half};
      default:
        o_result = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the DC bus, waits for the
// data-cache response, aligns load data, feeds WB and bypass.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
  input  logic [31:0]             dcache_rdata,
  input  logic                    dcache_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    stallreq_mem
);

  dc_to_mem_t r_bus;
  mem_st_e    r_state;
  logic [31:0] r_buf;

  logic        w_ld;
  logic        w_in_hold;
  logic        w_stallreq;
  logic        w_wb_stop;
  logic        w_own_stop;
  logic        w_keep;
  logic [31:0] w_word;
  logic [31:0] w_ld_data;
  logic [31:0] w_wdata;
  logic        w_we;
  mem_to_wb_t  w_wb;
  mem_to_rf_t  w_rf;
  logic        w_unused;

  assign w_ld       = r_bus.valid & r_bus.is_load;
  assign w_in_hold  = (r_state == S_HOLD);
  assign w_wb_stop  = (stall[STALL_WB] == STOP);
  assign w_own_stop = (stall[STALL_OWN] == STOP);

  assign w_stallreq = w_ld & ~w_in_hold
                    & ~dcache_rvalid;

  // Never drop a load whose data is still owed to WB.
  assign w_keep = w_stallreq | (w_ld & w_wb_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus <= '0;
    end else if (!w_keep) begin
      if (w_own_stop && !w_wb_stop)
        r_bus <= '0;
      else if (!w_own_stop)
        r_bus <= dc_to_mem_bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ld && !dcache_rvalid) begin
            r_state <= S_WAIT;
          end else if (w_ld && w_wb_stop) begin
            r_state <= S_HOLD;
            r_buf   <= dcache_rdata;
          end
        end
        S_WAIT: begin
          if (dcache_rvalid && w_wb_stop) begin
            r_state <= S_HOLD;
            r_buf   <= dcache_rdata;
          end else if (dcache_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!w_wb_stop)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_word = w_in_hold ? r_buf : dcache_rdata;

  load_align u_align (
    .i_ld_type (r_bus.ld_type),
    .i_addr    (r_bus.rf_wdata[1:0]),
    .i_word    (w_word),
    .o_result  (w_ld_data)
  );

  assign w_wdata = w_ld ? w_ld_data : r_bus.rf_wdata;
  assign w_we    = r_bus.rf_we & ~w_stallreq;

  always_comb begin
    w_wb          = '0;
    w_wb.hilo     = r_bus.hilo;
    w_wb.pc       = r_bus.pc;
    w_wb.rf_we    = w_we;
    w_wb.rf_waddr = r_bus.rf_waddr;
    w_wb.rf_wdata = w_wdata;
  end

  always_comb begin
    w_rf          = '0;
    w_rf.hilo     = r_bus.hilo;
    w_rf.rf_we    = w_we;
    w_rf.rf_waddr = r_bus.rf_waddr;
    w_rf.rf_wdata = w_wdata;
  end

  assign mem_to_wb_bus = w_wb;
  assign mem_to_rf_bus = w_rf;
  assign stallreq_mem  = w_stallreq;

  assign w_unused = ^{r_bus.rsv_hi, r_bus.rsv_lo,
                      stall[4:0]};

  // A response is only legal while a load is owed one.
  a_rvalid_proto: assert property (
    @(posedge clk) disable iff (!rst_n)
    dcache_rvalid |->
      (r_state == S_WAIT ||
       (r_state == S_IDLE && w_ld))
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed
// multi-cycle sequences and a randomized model comparison.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [6:0]   stall;
  logic [151:0] dc_bus;
  logic [31:0]  rdata;
  logic         rvalid;
  logic [135:0] wb;
  logic [103:0] rf;
  logic         sr;

  int total = 0;
  int bad   = 0;

  localparam logic [65:0] H = 66'h2_0123_4567_89AB_CDEF;

  mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .dc_to_mem_bus (dc_bus),
    .dcache_rdata  (rdata),
    .dcache_rvalid (rvalid),
    .mem_to_wb_bus (wb),
    .mem_to_rf_bus (rf),
    .stallreq_mem  (sr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    bit          ld;
    logic [2:0]  t;
    logic [31:0] addr;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } cm_t;

  task automatic chk(input string nm,
                     input logic [135:0] act,
                     input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [151:0] mk(
    input bit ld, input logic [2:0] t,
    input logic [31:0] pc, input bit we,
    input logic [4:0] wa, input logic [31:0] wd,
    input logic [65:0] h);
    return {ld, t, 5'b0, h, pc, 6'b0, 1'b1,
            we, wa, wd};
  endfunction

  function automatic logic [135:0] ewb(
    input logic [65:0] h, input logic [31:0] pc,
    input bit we, input logic [4:0] wa,
    input logic [31:0] wd);
    return {h, pc, we, wa, wd};
  endfunction

  function automatic logic [103:0] erf(
    input logic [65:0] h, input bit we,
    input logic [4:0] wa, input logic [31:0] wd);
    return {h, we, wa, wd};
  endfunction

  // Reference extraction by plain arithmetic.
  function automatic logic [31:0] ref_align(
    input logic [31:0] w, input logic [2:0] t,
    input logic [1:0] a);
    int unsigned b, h, sh;
    int s;
    sh = 8 * int'(a);
    b  = (w >> sh) & 32'hFF;
    sh = (a >= 2) ? 16 : 0;
    h  = (w >> sh) & 32'hFFFF;
    case (t)
      3'd0: begin
        s = (b >= 128) ? int'(b) - 256 : int'(b);
        return s;
      end
      3'd1: return b;
      3'd2: begin
        s = (h >= 32768) ? int'(h) - 65536 : int'(h);
        return s;
      end
      3'd3: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [151:0] rnd_instr();
    int k;
    logic [65:0] h;
    k = $urandom_range(0, 9);
    h = {$urandom, $urandom, 2'($urandom)};
    if (k < 2) return '0;
    return mk(k < 6, 3'($urandom_range(0, 4)),
              $urandom, k != 9, 5'($urandom),
              $urandom, h);
  endfunction

  vec_t tv[10];
  cm_t  q[$];
  cm_t  e;
  int   ncommit;
  logic [31:0] pc;

  initial begin
    bit inflight, responded, wbstop, cap, exp_sr;
    int lat;
    logic [31:0] rd;

    tv[0] = '{0, LD_LW,  32'h1234_5678, 32'h0,
              32'h1234_5678};
    tv[1] = '{1, LD_LB,  32'h0000_1003, 32'h80FF_0000,
              32'hFFFF_FF80};
    tv[2] = '{1, LD_LHU, 32'h0000_2002, 32'h8001_7FFF,
              32'h0000_8001};
    tv[3] = '{1, LD_LBU, 32'h0000_0002, 32'h80FF_0000,
              32'h0000_00FF};
    tv[4] = '{1, LD_LH,  32'h0000_0000, 32'h8001_7FFF,
              32'h0000_7FFF};
    tv[5] = '{1, LD_LH,  32'h0000_0002, 32'h8001_7FFF,
              32'hFFFF_8001};
    tv[6] = '{1, LD_LB,  32'h0000_0002, 32'h80FF_0000,
              32'hFFFF_FFFF};
    tv[7] = '{1, LD_LBU, 32'h0000_0000, 32'h1234_5678,
              32'h0000_0078};
    tv[8] = '{1, LD_LW,  32'h0000_0000, 32'hDEAD_BEEF,
              32'hDEAD_BEEF};
    tv[9] = '{1, LD_LB,  32'h0000_0001, 32'h1234_5678,
              32'h0000_0056};

    stall  = '0;
    dc_bus = '0;
    rdata  = '0;
    rvalid = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wb", wb, '0);
    chk("rst_rf", rf, '0);
    chk("rst_sr", sr, 0);
    chk("rst_st", dut.r_state, S_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-result vectors: ALU op and same-cycle loads
    foreach (tv[i]) begin
      pc = 32'h1000 + 32'(4 * i);
      dc_bus = mk(tv[i].ld, tv[i].t, pc, 1'b1, 5'd5,
                  tv[i].addr, H);
      cyc();
      dc_bus = '0;
      rvalid = tv[i].ld;
      rdata  = tv[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_wb", i), wb,
          ewb(H, pc, 1'b1, 5'd5, tv[i].exp));
      chk($sformatf("vec%0d_rf", i), rf,
          erf(H, 1'b1, 5'd5, tv[i].exp));
      chk($sformatf("vec%0d_sr", i), sr, 0);
      cyc();
      rvalid = 1'b0;
    end

    // LB with two wait cycles
    pc = 32'h2000;
    dc_bus = mk(1, LD_LB, pc, 1, 5'd9,
                32'h0000_1003, H);
    cyc();
    dc_bus = '0;
    stall  = 7'h3F;
    @(negedge clk);
    chk("lbw_sr1", sr, 1);
    chk("lbw_we1", wb[37], 0);
    chk("lbw_rfwe1", rf[37], 0);
    cyc();
    @(negedge clk);
    chk("lbw_sr2", sr, 1);
    chk("lbw_rfwe2", rf[37], 0);
    cyc();
    stall  = '0;
    rvalid = 1'b1;
    rdata  = 32'h80FF_0000;
    @(negedge clk);
    chk("lbw_sr3", sr, 0);
    chk("lbw_wb", wb,
        ewb(H, pc, 1, 5'd9, 32'hFFFF_FF80));
    chk("lbw_rf", rf,
        erf(H, 1, 5'd9, 32'hFFFF_FF80));
    cyc();
    rvalid = 1'b0;
    @(negedge clk);
    chk("lbw_after", wb, '0);

    // LW response while WB is stopped for three cycles
    pc = 32'h3000;
    ncommit = 0;
    dc_bus = mk(1, LD_LW, pc, 1, 5'd12,
                32'h0000_2000, H);
    cyc();
    dc_bus = '0;
    stall  = 7'h3F;
    @(negedge clk);
    chk("hold_sr0", sr, 1);
    for (int k = 0; k < 7; k++) begin
      cyc();
      rvalid = (k == 0);
      rdata  = (k == 0) ? 32'hDEAD_BEEF
                        : 32'h1111_1111;
      stall  = (k < 3) ? 7'h7F : 7'h00;
      @(negedge clk);
      if (k < 3)
        chk($sformatf("hold_sr%0d", k + 1), sr, 0);
      if (k == 1)
        chk("hold_state", dut.r_state, S_HOLD);
      if (k == 3)
        chk("hold_wb", wb,
            ewb(H, pc, 1, 5'd12, 32'hDEAD_BEEF));
      if (!stall[6] && wb[37] &&
          wb[31:0] == 32'hDEAD_BEEF)
        ncommit++;
    end
    rvalid = 1'b0;
    chk("hold_once", 136'(ncommit), 136'd1);

    // Own-stage stop with WB running inserts a bubble
    pc = 32'h4000;
    dc_bus = mk(0, 3'd0, pc, 1, 5'd5,
                32'h1234_5678, H);
    cyc();
    dc_bus = mk(0, 3'd0, pc + 4, 1, 5'd6,
                32'h0BAD_0BAD, H);
    stall  = 7'b010_0000;
    @(negedge clk);
    chk("bub_pre", wb,
        ewb(H, pc, 1, 5'd5, 32'h1234_5678));
    cyc();
    stall  = '0;
    dc_bus = '0;
    @(negedge clk);
    chk("bub_wb", wb, '0);
    chk("bub_we", wb[37], 0);

    // Reset in the middle of a wait
    pc = 32'h5000;
    dc_bus = mk(1, LD_LW, pc, 1, 5'd3,
                32'h0000_0100, H);
    cyc();
    dc_bus = '0;
    stall  = 7'h3F;
    cyc();
    @(negedge clk);
    chk("rw_sr", sr, 1);
    chk("rw_state", dut.r_state, S_WAIT);
    rst_n = 1'b0;
    #1;
    chk("rw_wb", wb, '0);
    chk("rw_rf", rf, '0);
    chk("rw_sr0", sr, 0);
    chk("rw_idle", dut.r_state, S_IDLE);
    cyc();
    rst_n = 1'b1;
    stall = '0;
    pc = 32'h6000;
    dc_bus = mk(1, LD_LW, pc, 1, 5'd7,
                32'h0000_3000, H);
    cyc();
    dc_bus = '0;
    stall  = 7'h3F;
    @(negedge clk);
    chk("rw2_sr", sr, 1);
    cyc();
    stall  = '0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rw2_wb", wb,
        ewb(H, pc, 1, 5'd7, 32'hCAFE_F00D));
    cyc();
    rvalid = 1'b0;

    // Randomized stream against commit-order model
    inflight  = 0;
    responded = 0;
    lat       = 0;
    rd        = '0;
    stall     = '0;
    dc_bus    = rnd_instr();
    for (int c = 0; c < 640; c++) begin
      cap = (stall[5] == 1'b0);
      cyc();
      if (cap) begin
        inflight = 0;
        if (dc_bus[38] && dc_bus[37]) begin
          e.wa = dc_bus[36:32];
          e.pc = dc_bus[76:45];
          if (dc_bus[151]) begin
            inflight  = 1;
            responded = 0;
            lat = $urandom_range(0, 3);
            rd  = $urandom;
            e.wd = ref_align(rd, dc_bus[150:148],
                             dc_bus[1:0]);
          end else begin
            e.wd = dc_bus[31:0];
          end
          q.push_back(e);
        end
        dc_bus = (c < 600) ? rnd_instr() : '0;
      end
      if (inflight && !responded && lat == 0) begin
        rvalid    = 1'b1;
        rdata     = rd;
        responded = 1;
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
        if (inflight && !responded) lat--;
      end
      exp_sr = inflight && !responded;
      wbstop = (c < 600) &&
               ($urandom_range(0, 3) == 0);
      stall  = {wbstop,
                (wbstop || exp_sr) ? 6'h3F : 6'h00};
      @(negedge clk);
      if (sr !== exp_sr) begin
        chk($sformatf("rnd_sr_c%0d", c), sr, exp_sr);
      end else begin
        total++;
      end
      if (!stall[6] && wb[37]) begin
        if (q.size() == 0) begin
          chk("rnd_extra_commit", wb[36:0], '0);
        end else begin
          e = q.pop_front();
          chk($sformatf("rnd_commit_c%0d", c),
              {wb[69:38], wb[36:32], wb[31:0]},
              {e.pc, e.wa, e.wd});
        end
      end
    end
    rvalid = 1'b0;
    chk("rnd_drained", 136'(q.size()), '0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
